// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: radix-2 shift-add multiply and restoring divide, one bit per clock.
// Optional feature macro: MULDIV_EARLY_OUT_EN (trivial/special operands bypass the iterative phase).
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            we_out
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t            state, next_state;
    logic [CW-1:0]     counter;
    logic [2:0]        op;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   mag_a, mag_b, hi, lo;
    logic              neg_res, b_zero;

    logic              accept, last_iter, early;
    logic              sign_a, sign_b, a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b, step_hi, step_lo, final_val, special_val;
    logic [XLEN-1:0]   q_fix, r_fix;
    logic [XLEN:0]     sum, shifted, diff;
    logic [2*XLEN-1:0] prod, prod_fix;

    assign accept    = (state == IDLE) && start && !flush;
    assign last_iter = (state == CALC) && (counter == CW'(XLEN - 1));

    // Operand sign interpretation and magnitudes for the requested op
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin sign_a = 1'b1; sign_b = 1'b1; end
            3'b010:                 begin sign_a = 1'b1; sign_b = 1'b0; end
            default:                begin sign_a = 1'b0; sign_b = 1'b0; end
        endcase
        a_neg = sign_a && rs1_val[XLEN-1];
        b_neg = sign_b && rs2_val[XLEN-1];
        abs_a = a_neg ? (~rs1_val + {{(XLEN-1){1'b0}}, 1'b1}) : rs1_val;
        abs_b = b_neg ? (~rs2_val + {{(XLEN-1){1'b0}}, 1'b1}) : rs2_val;
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Special operands resolved directly from the inputs
    always_comb begin
        early       = 1'b0;
        special_val = '0;
        if (funct3[2]) begin
            if (rs2_val == '0) begin
                early       = 1'b1;
                special_val = funct3[1] ? rs1_val : '1;
            end else if (rs1_val == '0) begin
                early       = 1'b1;
                special_val = '0;
            end else if (!funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1)) begin
                early       = 1'b1;
                special_val = funct3[1] ? '0 : rs1_val;
            end else begin
                early       = 1'b0;
                special_val = '0;
            end
        end else begin
            early       = (rs1_val == '0) || (rs2_val == '0);
            special_val = '0;
        end
    end
`else
    assign early       = 1'b0;
    assign special_val = '0;
`endif

    // One radix-2 iteration plus sign fix-up of the finished value
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : {(XLEN+1){1'b0}});
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, mag_b};
        if (op[2]) begin
            if (!diff[XLEN]) begin
                step_hi = diff[XLEN-1:0];
                step_lo = {lo[XLEN-2:0], 1'b1};
            end else begin
                step_hi = shifted[XLEN-1:0];
                step_lo = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            {step_hi, step_lo} = {sum, lo[XLEN-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = neg_res ? (~prod + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod;
        q_fix    = neg_res ? (~step_lo + {{(XLEN-1){1'b0}}, 1'b1}) : step_lo;
        r_fix    = neg_res ? (~step_hi + {{(XLEN-1){1'b0}}, 1'b1}) : step_hi;
        case (op)
            3'b000:                 final_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_val = b_zero ? '1 : q_fix;
            3'b110, 3'b111:         final_val = r_fix;
            default:                final_val = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) next_state = early ? DONE : CALC;
                else        next_state = IDLE;
            end
            CALC: begin
                if (flush)          next_state = IDLE;
                else if (last_iter) next_state = DONE;
                else                next_state = CALC;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
            op      <= 3'b000;
            rd_q    <= 5'd0;
            mag_a   <= '0;
            mag_b   <= '0;
            hi      <= '0;
            lo      <= '0;
            neg_res <= 1'b0;
            b_zero  <= 1'b0;
            result  <= '0;
            rd_out  <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            we_out  <= 1'b0;
        end else begin
            if (accept) begin
                op      <= funct3;
                rd_q    <= rd_in;
                mag_a   <= abs_a;
                mag_b   <= abs_b;
                hi      <= '0;
                lo      <= funct3[2] ? abs_a : abs_b;
                counter <= '0;
                // Remainder follows the dividend; everything else follows the operand sign product
                neg_res <= (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
                b_zero  <= (rs2_val == '0);
                if (early) begin
                    result <= special_val;
                    rd_out <= rd_in;
                end
            end else if ((state == CALC) && !flush) begin
                hi      <= step_hi;
                lo      <= step_lo;
                counter <= counter + CW'(1);
                if (last_iter) begin
                    result <= final_val;
                    rd_out <= rd_q;
                end
            end
            busy   <= (next_state == CALC);
            done   <= (next_state == DONE);
            we_out <= (next_state == DONE) && (accept ? (rd_in != 5'd0) : (rd_q != 5'd0));
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level reference model plus directed vectors.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_val = 32'd0;
    logic [31:0] rs2_val = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        flush = 1'b0;
    logic        busy, done, we_out;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out), .we_out(we_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Architectural reference: RV32M semantics from plain arithmetic
    function automatic logic [31:0] ref_calc(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Cycle-level expectation: an accepted op completes 33 cycles after its start cycle
    logic        e_busy, e_done, e_we;
    logic [31:0] e_result, pend_result;
    logic [4:0]  e_rd, pend_rd;
    int          remaining;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_busy <= 1'b0; e_done <= 1'b0; e_we <= 1'b0;
            e_result <= 32'd0; e_rd <= 5'd0; remaining <= 0;
            pend_result <= 32'd0; pend_rd <= 5'd0;
        end else begin
            e_done <= 1'b0;
            e_we   <= 1'b0;
            if (remaining != 0) begin
                if (flush) begin
                    remaining <= 0;
                    e_busy    <= 1'b0;
                end else if (remaining == 1) begin
                    remaining <= 0;
                    e_busy    <= 1'b0;
                    e_done    <= 1'b1;
                    e_result  <= pend_result;
                    e_rd      <= pend_rd;
                    e_we      <= (pend_rd != 5'd0);
                end else begin
                    remaining <= remaining - 1;
                end
            end else if (!e_done && start && !flush) begin
                remaining   <= 32;
                e_busy      <= 1'b1;
                pend_result <= ref_calc(funct3, rs1_val, rs2_val);
                pend_rd     <= rd_in;
            end
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk) begin
        checks++;
        if (busy !== e_busy || done !== e_done || we_out !== e_we || result !== e_result || rd_out !== e_rd) begin
            failures++;
            $display("FAIL model cyc=%0d got busy=%b done=%b we=%b result=%h rd=%0d expected busy=%b done=%b we=%b result=%h rd=%0d",
                     cyc, busy, done, we_out, result, rd_out, e_busy, e_done, e_we, e_result, e_rd);
        end
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] expv, input string name);
        int  t0;
        bit  found;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; rd_in = rd; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        check(found, {name, "_done_seen"}, 32'(found), 32'd1);
        if (found) begin
            check((cyc - t0) == 33, {name, "_latency"}, 32'(cyc - t0), 32'd33);
            check(result === expv, {name, "_result"}, result, expv);
            check(rd_out === rd, {name, "_rd"}, 32'(rd_out), 32'(rd));
            check(we_out === (rd != 5'd0), {name, "_we"}, 32'(we_out), 32'(rd != 5'd0));
        end
    endtask

    int          ndone, dcyc, t0;
    logic [31:0] prev;

    initial begin
        // Model pins against hand-computed values
        check(ref_calc(3'd0, 32'd7, 32'hFFFF_FFFD) == 32'hFFFF_FFEB, "ref_mul", ref_calc(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check(ref_calc(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF) == 32'hFFFF_FFFE, "ref_mulhu", ref_calc(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check(ref_calc(3'd4, 32'hFFFF_FFF9, 32'd2) == 32'hFFFF_FFFD, "ref_div", ref_calc(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check(ref_calc(3'd6, 32'h8000_0000, 32'hFFFF_FFFF) == 32'd0, "ref_rem_ovf", ref_calc(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check(busy === 1'b0 && done === 1'b0 && we_out === 1'b0 && result === 32'd0 && rd_out === 5'd0,
              "reset_state", result, 32'd0);
        #1 rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, "mul_7x-3");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, "mulhu_ff");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, "mulh_ff");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, "mulhsu_ff");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, "div_-7_2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, "rem_-7_2");
        run_op(3'd5, 32'd100, 32'd0, 5'd7, 32'hFFFF_FFFF, "divu_by0");
        run_op(3'd7, 32'd100, 32'd0, 5'd8, 32'd100, "remu_by0");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd9, 32'hFFFF_FFFF, "div_neg_by0");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd10, 32'hFFFF_FFF9, "rem_neg_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'd0, "rem_ovf_rd0");
        run_op(3'd5, 32'd1000, 32'd7, 5'd12, 32'd142, "divu_1000_7");
        run_op(3'd7, 32'd1000, 32'd7, 5'd13, 32'd6, "remu_1000_7");
        run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, ref_calc(3'd0, 32'h1234_5678, 32'h9ABC_DEF0), "mul_mix");

        // Start while busy and in the DONE cycle: both ignored, single done pulse
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd5; rs1_val = 32'd50; rs2_val = 32'd5; rd_in = 5'd15; t0 = cyc;
        ndone = 0; dcyc = 0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk); #1;
            start = (i == 10) || (i == 33);
            rs1_val = 32'd99;
            @(negedge clk);
            if (done) begin ndone++; dcyc = cyc - t0; end
        end
        start = 1'b0;
        check(ndone == 1, "ignored_start_pulses", 32'(ndone), 32'd1);
        check(dcyc == 33, "ignored_start_latency", 32'(dcyc), 32'd33);
        check(result === 32'd10, "ignored_start_result", result, 32'd10);

        // Flush in cycle 5 of CALC: no done, result unchanged
        prev = result;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd4; rd_in = 5'd16;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check(busy === 1'b0, "flush_busy_low", 32'(busy), 32'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check(ndone == 0, "flush_no_done", 32'(ndone), 32'd0);
        check(result === prev, "flush_result_held", result, prev);

        // Flush together with start in IDLE: start ignored
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check(busy === 1'b0, "flush_start_idle", 32'(busy), 32'd0);

        // Reset mid-operation
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd4; rs1_val = 32'd77; rs2_val = 32'd7; rd_in = 5'd17;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check(busy === 1'b0 && done === 1'b0 && we_out === 1'b0 && result === 32'd0 && rd_out === 5'd0,
              "reset_mid_op", result, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        run_op(3'd4, 32'd77, 32'hFFFF_FFF9, 5'd18, 32'hFFFF_FFF5, "div_after_reset");

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
